// File: rtl/mem_io_responder.sv
// Load/store responder: services core memory strobes through a 1-cycle BRAM port,
// and I/O strobes from local LED, 7-segment and debounced-switch registers.
module mem_io_responder #(
  parameter int unsigned DMEM_AW         = 14,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  LED_OFS         = 8'h60,
  parameter logic [7:0]  SW_OFS          = 8'h70,
  parameter logic [7:0]  SEG_OFS         = 8'h80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               io_read,
  input  logic               io_write,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               dmem_we,
  input  logic [31:0]        dmem_rdata,
  input  logic [15:0]        switch_in,
  output logic [15:0]        led_out,
  output logic [31:0]        seg_value
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;

  state_t      state_q, state_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] deb_q, deb_d;
  logic [19:0] cnt_q, cnt_d;

  logic [7:0]  ofs;
  logic        idle;
  logic        do_iwr, do_ird, do_mwr, do_mrd;
  logic        unused_addr_bits;

  assign ofs  = addr[7:0];
  assign unused_addr_bits = ^{addr[31:DMEM_AW+2], addr[1:0]};

  // Priority decode: io_write > io_read > mem_write > mem_read, only when idle.
  assign idle   = (state_q == IDLE) & ~rst;
  assign do_iwr = idle & io_write;
  assign do_ird = idle & io_read & ~io_write;
  assign do_mwr = idle & mem_write & ~io_write & ~io_read;
  assign do_mrd = idle & mem_read & ~mem_write & ~io_write & ~io_read;

  assign dmem_addr  = addr[DMEM_AW+1:2];
  assign dmem_wdata = wdata;
  assign dmem_we    = do_mwr;
  assign busy       = do_mrd;
  assign led_out    = led_q;
  assign seg_value  = seg_q;

  always_comb begin
    rdata = '0;
    if (!rst && state_q == LOAD_WAIT) begin
      rdata = dmem_rdata;
    end else if (do_ird) begin
      if (ofs == SW_OFS)       rdata = {16'h0, deb_q};
      else if (ofs == LED_OFS) rdata = {16'h0, led_q};
      else if (ofs == SEG_OFS) rdata = seg_q;
    end
  end

  always_comb begin
    state_d = do_mrd ? LOAD_WAIT : IDLE;
    led_d   = led_q;
    seg_d   = seg_q;
    if (do_iwr) begin
      if (ofs == LED_OFS)      led_d = wdata[15:0];
      else if (ofs == SEG_OFS) seg_d = wdata;
    end
  end

  // A synced value about to change (sync1 != sync2) restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q || sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= '0;
      seg_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      sync1_q <= switch_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: transaction-level reference model,
// external BRAM model, and a negedge monitor comparing every cycle's outputs.
module tb_mem_io_responder;
  localparam int AW = 14;
  localparam int DB = 8;
  localparam logic [7:0] LED = 8'h60;
  localparam logic [7:0] SW  = 8'h70;
  localparam logic [7:0] SEG = 8'h80;

  localparam int K_IDLE = 0, K_IOWR = 1, K_IORD = 2, K_STORE = 3,
                 K_LREQ = 4, K_LDATA = 5, K_RST = 6;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] addr, wdata, rdata, dmem_wdata, dmem_rdata, seg_value;
  logic mem_read, mem_write, io_read, io_write, busy, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [15:0] switch_in, led_out;

  always #5 clk = ~clk;

  mem_io_responder #(
    .DMEM_AW(AW), .DEBOUNCE_CYCLES(20'(DB)),
    .LED_OFS(LED), .SW_OFS(SW), .SEG_OFS(SEG)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .rdata(rdata), .busy(busy), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .switch_in(switch_in),
    .led_out(led_out), .seg_value(seg_value)
  );

  // External block RAM: synchronous write, 1-cycle registered read.
  logic [31:0] bram [0:(1<<AW)-1];
  logic pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) bram[pl_addr] <= pl_data;
    else if (dmem_we) bram[dmem_addr] <= dmem_wdata;
    dmem_rdata <= bram[dmem_addr];
  end

  typedef struct packed {
    int kind;
    logic [31:0] rdata;
    logic busy;
    logic we;
    logic chk_addr;
    logic [AW-1:0] daddr;
    logic [31:0] wd;
    logic [15:0] led;
    logic [31:0] seg;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [15:0] m_led, m_seg_lo;
  logic [31:0] m_seg;
  logic [15:0] m_deb, m_last;
  int m_run;

  function automatic string kname(input int k);
    case (k)
      K_IDLE:  return "idle";
      K_IOWR:  return "io_write";
      K_IORD:  return "io_read";
      K_STORE: return "store";
      K_LREQ:  return "load_req";
      K_LDATA: return "load_data";
      K_RST:   return "reset";
      default: return "other";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic exp_t mk_exp(input int k, input logic [AW-1:0] w, input logic [31:0] wd);
    exp_t e;
    e.kind = k; e.rdata = '0; e.busy = 1'b0; e.we = 1'b0; e.chk_addr = 1'b0;
    e.daddr = w; e.wd = wd; e.led = m_led; e.seg = m_seg;
    return e;
  endfunction

  function automatic logic [31:0] io_value(input logic [7:0] ofs);
    if (ofs == SW)  return {16'h0, m_deb};
    if (ofs == LED) return {16'h0, m_led};
    if (ofs == SEG) return m_seg;
    return 32'h0;
  endfunction

  // Switch model: a raw value sampled identically on DB+1 consecutive edges
  // (two synchronizer stages, then DB stable cycles) becomes the debounced value.
  task automatic reset_sw_model();
    m_deb = '0; m_last = '0; m_run = 1;
  endtask

  task automatic edge_sw();
    if (rst) begin
      reset_sw_model();
      m_led = '0; m_seg = '0;
    end else begin
      if (m_run >= DB + 1 && m_last != m_deb) m_deb = m_last;
      if (switch_in == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = switch_in; m_run = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_sw();
    #1;
  endtask

  task automatic apply(input logic rd, wr, ird, iwr, input logic [31:0] a, wd);
    mem_read = rd; mem_write = wr; io_read = ird; io_write = iwr;
    addr = a; wdata = wd;
  endtask

  task automatic txn(input logic rd, wr, ird, iwr, input logic [31:0] a, wd, input logic perturb);
    exp_t e;
    logic [AW-1:0] w;
    logic [31:0] r;
    w = a[AW+1:2];
    apply(rd, wr, ird, iwr, a, wd);
    e = mk_exp(K_IDLE, w, wd);
    if (iwr) e.kind = K_IOWR;
    else if (ird) begin e.kind = K_IORD; e.rdata = io_value(a[7:0]); end
    else if (wr) begin e.kind = K_STORE; e.we = 1'b1; e.chk_addr = 1'b1; end
    else if (rd) begin e.kind = K_LREQ; e.busy = 1'b1; e.chk_addr = 1'b1; end
    q.push_back(e);
    tick();
    if (iwr) begin
      if (a[7:0] == LED) m_led = wd[15:0];
      else if (a[7:0] == SEG) m_seg = wd;
    end else if (!ird && wr) begin
      ref_mem[int'(w)] = wd;
    end else if (!ird && rd) begin
      // Core is stalled; any strobes seen now must be ignored.
      if (perturb) begin
        r = $urandom;
        apply(r[0], r[1], r[2], r[3], $urandom, $urandom);
      end
      e = mk_exp(K_LDATA, w, wd);
      e.rdata = ref_mem[int'(w)];
      q.push_back(e);
      tick();
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t me;
    string nm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        nm = kname(me.kind);
        check({nm, ".busy"}, {31'b0, busy}, {31'b0, me.busy});
        check({nm, ".rdata"}, rdata, me.rdata);
        check({nm, ".dmem_we"}, {31'b0, dmem_we}, {31'b0, me.we});
        if (me.chk_addr) check({nm, ".dmem_addr"}, 32'(dmem_addr), 32'(me.daddr));
        if (me.we) check({nm, ".dmem_wdata"}, dmem_wdata, me.wd);
        check({nm, ".led_out"}, {16'h0, led_out}, {16'h0, me.led});
        check({nm, ".seg_value"}, seg_value, me.seg);
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    switch_in = '0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    m_led = '0; m_seg = '0; m_seg_lo = '0;
    reset_sw_model();
    @(posedge clk); #1;

    // Preload BRAM words 0..15 while in reset
    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1;
      pl_addr = AW'(i);
      pl_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;

    // Outputs held quiet in reset even with strobes asserted
    apply(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0);
    e = mk_exp(K_RST, 14'd24, 32'h0);
    q.push_back(e);
    tick();
    rst = 1'b0;

    // Load from word 4, then idle, then a fresh load
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

    // Store then load back
    txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    // Read and write together: write wins
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'hCAFE_0001, 1'b0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 32'h0, 1'b0);

    // LED register write, unmapped write, readback
    txn(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FC60, 32'h0001_A5A5, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FC64, 32'h0000_1111, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FC60, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FC64, 32'h0, 1'b0);

    // Debounce with a 3-cycle glitch, polled through the switch register
    switch_in = 16'h00F0;
    for (int i = 0; i < 5; i++) txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 1'b0);
    switch_in = 16'h0000;
    for (int i = 0; i < 3; i++) txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 1'b0);
    switch_in = 16'h00F0;
    for (int i = 0; i < 14; i++) txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a load
    txn(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FC60, 32'h0000_FFFF, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0);
    e = mk_exp(K_LREQ, 14'd3, 32'h0);
    e.busy = 1'b1; e.chk_addr = 1'b1;
    q.push_back(e);
    tick();
    #2 rst = 1'b1;
    m_led = '0; m_seg = '0;
    reset_sw_model();
    e = mk_exp(K_RST, 14'd3, 32'h0);
    q.push_back(e);
    @(posedge clk);
    edge_sw();
    #2 rst = 1'b0;
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 1'b0);

    // I/O write beats a simultaneous memory read
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FC80, 32'h0000_0007, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FC80, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r, a;
      logic [7:0] ofs;
      logic rd, wr, ird, iwr;
      r = $urandom;
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 15));
      rd  = r[0];
      wr  = r[1] & r[4];
      ird = r[2] & r[3];
      iwr = r[5] & r[6] & r[7];
      case (r[10:8])
        3'd0:    ofs = LED;
        3'd1:    ofs = SW;
        3'd2:    ofs = SEG;
        3'd3:    ofs = 8'h64;
        default: ofs = 8'($urandom);
      endcase
      if (ird | iwr) a[7:0] = ofs;
      if (r[15:12] == 4'd0) switch_in = 16'($urandom);
      txn(rd, wr, ird, iwr, a, $urandom, 1'b1);
    end

    @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder side of the core's load/store control interface.
- Accepts the controller's decoded strobes (mem_read, mem_write, io_read, io_write) with the ALU address and store data, and services them.
- Data memory is serviced through a synchronous 1-cycle-latency block RAM port. I/O is serviced from on-block LED, 7-segment and debounced-switch registers.
- Returns load data to the writeback mux and raises busy to stall the core while a memory load is outstanding.

Parameters:
- DMEM_AW, 14, data-memory word-address width (dmem_addr = addr[DMEM_AW+1:2]).
- DEBOUNCE_CYCLES, 20'd500000, cycles a synchronized switch value must stay stable before it is accepted (>=2).
- LED_OFS, 8'h60, I/O offset of the LED register (addr[7:0]).
- SW_OFS, 8'h70, I/O offset of the switch register.
- SEG_OFS, 8'h80, I/O offset of the 7-segment value register.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- addr  in  32  byte address from ALU result
- wdata  in  32  store data (rs2)
- mem_read  in  1  memory load request
- mem_write  in  1  memory store request
- io_read  in  1  I/O load request
- io_write  in  1  I/O store request
- rdata  out  32  load data to writeback mux
- busy  out  1  stall request to core (hold PC and IF/ID)
- dmem_addr  out  DMEM_AW  BRAM word address
- dmem_wdata  out  32  BRAM write data
- dmem_we  out  1  BRAM write enable
- dmem_rdata  in  32  BRAM read data, valid 1 cycle after address
- switch_in  in  16  raw board switches (asynchronous)
- led_out  out  16  LED drive register
- seg_value  out  32  value for 7-segment display driver

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0; rdata=0; led_out=0; seg_value=0.
  - Switch sync flops = 0; debounced switch register = 0; debounce counter = 0.
  - Release of rst is synchronous to clk (first active edge after deassert).
- FSM states:
  - IDLE: default.
  - LOAD_WAIT: BRAM read in flight.
- Request priority in IDLE, highest first: io_write, io_read, mem_write, mem_read. Lower-priority strobes in the same cycle are ignored.
- Memory load:
  - Cycle N, state IDLE, mem_read=1 (no higher strobe): dmem_addr=addr[DMEM_AW+1:2]; busy=1 combinationally; next state LOAD_WAIT.
  - Cycle N+1, LOAD_WAIT: rdata=dmem_rdata (combinational pass-through); busy=0; next state IDLE.
  - The core holds addr/strobes stable while busy=1. Total load latency is 2 cycles: exactly one stall cycle.
- Memory store: single cycle. dmem_we = mem_write & (state==IDLE) & no I/O strobe; dmem_wdata=wdata; busy=0.
- I/O write (single cycle, busy=0), decoded on addr[7:0]:
  - LED_OFS: led_out <= wdata[15:0] at the clock edge.
  - SEG_OFS: seg_value <= wdata.
  - Other offsets: write ignored, no register changes.
- I/O read (single cycle, busy=0):
  - SW_OFS: rdata = {16'h0, debounced switches}.
  - LED_OFS: rdata = {16'h0, led_out}.
  - SEG_OFS: rdata = seg_value.
  - Unmapped offsets: rdata = 0.
- rdata is 0 when no read is being serviced.
- Switch path:
  - 2-flop synchronizer, then the debouncer.
  - If synced value != debounced value, counter increments. At DEBOUNCE_CYCLES-1 the debounced register takes the synced value and the counter clears.
  - If synced value == debounced value, counter clears.
  - A change of the synced value mid-count also restarts the count from 0.
- Boundaries:
  - In LOAD_WAIT, any new strobes are ignored (the core is stalled); dmem_we=0.
  - mem_read & mem_write together: the write is performed and the read is dropped.
  - I/O strobe together with a mem strobe: the I/O access wins; dmem_we=0.
  - rst during LOAD_WAIT: immediate return to IDLE, busy=0, and the pending load is discarded.
  - Address bits above the decoded ranges are don't-care; dmem_addr wraps modulo 2^DMEM_AW.

Test Plan:
1. Reset, then hold mem_read=1, addr=0x0000_0010, with BRAM word 4 preloaded to 0xDEADBEEF. Required: busy=1 in cycle N, busy=0 and rdata=0xDEADBEEF in N+1, state back to IDLE in N+2.
2. mem_write=1, addr=0x0000_0020, wdata=0x12345678. Required: dmem_we=1, dmem_addr=8, busy=0 for one cycle. A following load of the same address returns 0x12345678.
3. io_write=1, addr=0xFFFF_FC60, wdata=0x0001_A5A5. Required: led_out=16'hA5A5 after the edge. A write to offset 0x64 leaves led_out unchanged. io_read at 0x60 returns 0x0000A5A5.
4. DEBOUNCE_CYCLES=8; switch_in 0 -> 16'h00F0 with a 3-cycle glitch back to 0 partway through.
   - Required: the debounced value stays 0 through the glitch.
   - It becomes 0x00F0 exactly 2 sync cycles + 8 stable cycles after the last change.
   - io_read at 0x70 then returns 0x000000F0.
5. Assert rst for 1 cycle during LOAD_WAIT with led_out=0xFFFF. Required: busy=0, rdata=0, led_out=0 immediately (async). The next mem_read starts a fresh 2-cycle load.
6. mem_read=1 and io_write=1 (addr=0xFFFF_FC80, wdata=7) in the same cycle. Required: seg_value=7, busy stays 0, dmem_we=0, no LOAD_WAIT entered.
